dht11_ascii_framer: RTL and testbench

Downstream consumer of the DHT11 acquisition block. On each completed reading it latches the 32-bit sample, converts the humidity and temperature bytes to decimal ASCII, and streams a fixed-format text line to the UART transmitter over a valid/ready byte interface. It sits between the sensor FSM (`done`, `raw_data`) and the board's UART TX.

---
 rtl/dht11_fmt_pkg.sv | 44 ++++
 rtl/dht11_ascii_framer_bcd.sv | 46 ++++
 rtl/dht11_ascii_framer.sv | 168 ++++++++++++++++
 tb/tb_dht11_ascii_framer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dht11_fmt_pkg.sv
// Shared definitions for the DHT11 text-line framer: state encoding, ASCII
// constants, line lengths and the conversion helpers.
package dht11_fmt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_EMIT
    } state_t;

    localparam logic [7:0] ASCII_H    = 8'h48;
    localparam logic [7:0] ASCII_T    = 8'h54;
    localparam logic [7:0] ASCII_EQ   = 8'h3D;
    localparam logic [7:0] ASCII_DOT  = 8'h2E;
    localparam logic [7:0] ASCII_SP   = 8'h20;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;
    localparam logic [7:0] ASCII_QM   = 8'h3F;
    localparam logic [7:0] ASCII_ZERO = 8'h30;

    localparam int LINE_LEN_DEC = 17;
    localparam int LINE_LEN_INT = 13;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return ASCII_ZERO + {4'h0, d};
    endfunction

    // The sensor's decimal byte is a single digit in practice; anything else is flagged.
    function automatic logic [7:0] frac_char(input logic [7:0] b);
        return (b <= 8'd9) ? (ASCII_ZERO + b) : ASCII_QM;
    endfunction

    // One double-dabble iteration on {hundreds, tens, units, binary}.
    function automatic logic [19:0] dabble_step(input logic [19:0] s);
        logic [19:0] r;
        r = s;
        for (int i = 0; i < 3; i++) begin
            if (r[8 + 4*i +: 4] >= 4'd5)
                r[8 + 4*i +: 4] = r[8 + 4*i +: 4] + 4'd3;
        end
        return {r[18:0], 1'b0};
    endfunction

endpackage

// File: rtl/dht11_ascii_framer_bcd.sv
// Iterative 8-bit binary to 3-digit BCD converter; result valid when done pulses,
// eight cycles after start, and held until the next start.
module bin8_to_bcd3
    import dht11_fmt_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  bin,
    output logic [11:0] bcd,
    output logic        done
);

    logic [19:0] shift_reg;
    logic [2:0]  iter_reg;
    logic        running_reg;
    logic        done_reg;

    // The first shift needs no add-3 correction, so it is folded into the load.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            iter_reg    <= '0;
            running_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (start) begin
                shift_reg   <= {11'd0, bin, 1'b0};
                iter_reg    <= 3'd1;
                running_reg <= 1'b1;
            end else if (running_reg) begin
                shift_reg <= dabble_step(shift_reg);
                iter_reg  <= iter_reg + 3'd1;
                if (iter_reg == 3'd7) begin
                    running_reg <= 1'b0;
                    done_reg    <= 1'b1;
                end
            end
        end
    end

    assign bcd  = shift_reg[19:8];
    assign done = done_reg;

endmodule

// File: rtl/dht11_ascii_framer.sv
// Turns each completed DHT11 reading into an ASCII line "H=hhh.d T=ttt.d\r\n"
// streamed over a valid/ready byte interface.
module dht11_ascii_framer
    import dht11_fmt_pkg::*;
#(
    parameter bit EMIT_DECIMAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dht_done,
    input  logic [31:0] dht_raw,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        frame_done,
    output logic        overrun
);

    localparam int         LINE_LEN = EMIT_DECIMAL ? LINE_LEN_DEC : LINE_LEN_INT;
    localparam logic [4:0] LAST_IDX = 5'(LINE_LEN - 1);

    state_t      state_reg;
    logic        done_q;
    logic [7:0]  rh_frac_reg;
    logic [7:0]  t_frac_reg;
    logic [4:0]  idx_reg;
    logic [7:0]  tx_data_reg;
    logic        tx_valid_reg;
    logic        busy_reg;
    logic        frame_done_reg;
    logic        overrun_reg;

    logic        edge_seen;
    logic        conv_start;
    logic [11:0] rh_bcd;
    logic [11:0] t_bcd;
    logic        rh_done;
    logic        t_done;
    logic [4:0]  mux_idx;
    logic [7:0]  mux_byte;

    assign edge_seen  = dht_done & ~done_q;
    assign conv_start = edge_seen && (state_reg == ST_IDLE);

    bin8_to_bcd3 u_rh_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (dht_raw[31:24]),
        .bcd   (rh_bcd),
        .done  (rh_done)
    );

    bin8_to_bcd3 u_t_bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .bin   (dht_raw[15:8]),
        .bcd   (t_bcd),
        .done  (t_done)
    );

    // Looks one byte ahead so tx_data can be registered without a bubble.
    always_comb begin
        mux_idx  = (state_reg == ST_EMIT) ? (idx_reg + 5'd1) : 5'd0;
        mux_byte = 8'h00;
        if (EMIT_DECIMAL) begin
            case (mux_idx)
                5'd0:    mux_byte = ASCII_H;
                5'd1:    mux_byte = ASCII_EQ;
                5'd2:    mux_byte = digit_char(rh_bcd[11:8]);
                5'd3:    mux_byte = digit_char(rh_bcd[7:4]);
                5'd4:    mux_byte = digit_char(rh_bcd[3:0]);
                5'd5:    mux_byte = ASCII_DOT;
                5'd6:    mux_byte = frac_char(rh_frac_reg);
                5'd7:    mux_byte = ASCII_SP;
                5'd8:    mux_byte = ASCII_T;
                5'd9:    mux_byte = ASCII_EQ;
                5'd10:   mux_byte = digit_char(t_bcd[11:8]);
                5'd11:   mux_byte = digit_char(t_bcd[7:4]);
                5'd12:   mux_byte = digit_char(t_bcd[3:0]);
                5'd13:   mux_byte = ASCII_DOT;
                5'd14:   mux_byte = frac_char(t_frac_reg);
                5'd15:   mux_byte = ASCII_CR;
                5'd16:   mux_byte = ASCII_LF;
                default: mux_byte = 8'h00;
            endcase
        end else begin
            case (mux_idx)
                5'd0:    mux_byte = ASCII_H;
                5'd1:    mux_byte = ASCII_EQ;
                5'd2:    mux_byte = digit_char(rh_bcd[11:8]);
                5'd3:    mux_byte = digit_char(rh_bcd[7:4]);
                5'd4:    mux_byte = digit_char(rh_bcd[3:0]);
                5'd5:    mux_byte = ASCII_SP;
                5'd6:    mux_byte = ASCII_T;
                5'd7:    mux_byte = ASCII_EQ;
                5'd8:    mux_byte = digit_char(t_bcd[11:8]);
                5'd9:    mux_byte = digit_char(t_bcd[7:4]);
                5'd10:   mux_byte = digit_char(t_bcd[3:0]);
                5'd11:   mux_byte = ASCII_CR;
                5'd12:   mux_byte = ASCII_LF;
                default: mux_byte = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            done_q         <= 1'b1;
            rh_frac_reg    <= '0;
            t_frac_reg     <= '0;
            idx_reg        <= '0;
            tx_data_reg    <= '0;
            tx_valid_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            done_q         <= dht_done;
            frame_done_reg <= 1'b0;
            overrun_reg    <= edge_seen && (state_reg != ST_IDLE);
            case (state_reg)
                ST_IDLE: begin
                    if (edge_seen) begin
                        rh_frac_reg <= dht_raw[23:16];
                        t_frac_reg  <= dht_raw[7:0];
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    if (rh_done && t_done) begin
                        idx_reg      <= '0;
                        tx_data_reg  <= mux_byte;
                        tx_valid_reg <= 1'b1;
                        state_reg    <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (tx_ready) begin
                        if (idx_reg == LAST_IDX) begin
                            idx_reg        <= '0;
                            tx_data_reg    <= '0;
                            tx_valid_reg   <= 1'b0;
                            busy_reg       <= 1'b0;
                            frame_done_reg <= 1'b1;
                            state_reg      <= ST_IDLE;
                        end else begin
                            idx_reg     <= idx_reg + 5'd1;
                            tx_data_reg <= mux_byte;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign tx_data    = tx_data_reg;
    assign tx_valid   = tx_valid_reg;
    assign busy       = busy_reg;
    assign frame_done = frame_done_reg;
    assign overrun    = overrun_reg;

endmodule

// File: tb/tb_dht11_ascii_framer.sv
// Directed bench for dht11_ascii_framer: both line formats run side by side on
// shared inputs; captured byte streams are compared with hand-written lines.
module tb_dht11_ascii_framer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dht_done = 1'b0;
    logic        tx_ready = 1'b0;
    logic [31:0] dht_raw = 32'h0;

    logic [7:0]  tx_data_v [2];
    logic [1:0]  tx_valid_v;
    logic [1:0]  busy_v;
    logic [1:0]  frame_done_v;
    logic [1:0]  overrun_v;

    always #5 clk = ~clk;

    dht11_ascii_framer #(.EMIT_DECIMAL(1'b0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .dht_done   (dht_done),
        .dht_raw    (dht_raw),
        .tx_data    (tx_data_v[0]),
        .tx_valid   (tx_valid_v[0]),
        .tx_ready   (tx_ready),
        .busy       (busy_v[0]),
        .frame_done (frame_done_v[0]),
        .overrun    (overrun_v[0])
    );

    dht11_ascii_framer #(.EMIT_DECIMAL(1'b1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .dht_done   (dht_done),
        .dht_raw    (dht_raw),
        .tx_data    (tx_data_v[1]),
        .tx_valid   (tx_valid_v[1]),
        .tx_ready   (tx_ready),
        .busy       (busy_v[1]),
        .frame_done (frame_done_v[1]),
        .overrun    (overrun_v[1])
    );

    typedef struct {
        logic [31:0] raw;
        string       line1;
        string       line0;
    } vec_t;

    vec_t        vecs [5];
    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    logic [7:0]  q0 [$];
    logic [7:0]  q1 [$];
    int          fd_cnt [2];
    int          fd_first [2];
    int          fd_last [2];
    int          ov_cnt [2];
    int          first_v [2];
    int          valid_cnt [2];
    int          stall_cnt = 0;
    logic        stalled [2];
    logic [7:0]  hold [2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Capture transfers and enforce data stability during stalls.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                stalled[k] = 1'b0;
            end else begin
                if (tx_valid_v[k] && tx_ready) begin
                    if (k == 0) q0.push_back(tx_data_v[k]);
                    else        q1.push_back(tx_data_v[k]);
                end
                if (tx_valid_v[k]) valid_cnt[k]++;
                if (tx_valid_v[k] && first_v[k] < 0) first_v[k] = cyc;
                if (frame_done_v[k]) begin
                    if (fd_cnt[k] == 0) fd_first[k] = cyc;
                    fd_last[k] = cyc;
                    fd_cnt[k]++;
                end
                if (overrun_v[k]) ov_cnt[k]++;
                if (stalled[k]) begin
                    stall_cnt++;
                    check($sformatf("stall_hold%0d", k), {23'd0, tx_valid_v[k], tx_data_v[k]},
                          {23'd0, 1'b1, hold[k]});
                end
                stalled[k] = tx_valid_v[k] && !tx_ready;
                hold[k]    = tx_data_v[k];
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        q0.delete();
        q1.delete();
        for (int k = 0; k < 2; k++) begin
            fd_cnt[k]    = 0;
            fd_first[k]  = -1;
            fd_last[k]   = -1;
            ov_cnt[k]    = 0;
            first_v[k]   = -1;
            valid_cnt[k] = 0;
        end
    endtask

    // Leaves dht_done rising in the returned cycle e.
    task automatic start_frame(input logic [31:0] raw, output int e);
        dht_done = 1'b0;
        tick(1);
        dht_raw  = raw;
        dht_done = 1'b1;
        e = cyc;
    endtask

    task automatic wait_done(input int target, input int budget);
        int t;
        t = 0;
        while (!(fd_cnt[0] >= target && fd_cnt[1] >= target) && t < budget) begin
            tick(1);
            t++;
        end
        check("frame_complete", {31'd0, (fd_cnt[0] >= target && fd_cnt[1] >= target)}, 32'd1);
    endtask

    task automatic check_line(input string name, input int k, input string body, input int reps);
        logic [7:0] exp [$];
        logic [7:0] got [$];
        int bad;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < body.len(); i++) exp.push_back(body[i]);
            exp.push_back(8'h0D);
            exp.push_back(8'h0A);
        end
        if (k == 0) got = q0;
        else        got = q1;
        n_checks++;
        bad = -1;
        if (got.size() != exp.size()) begin
            n_fail++;
            $display("FAIL %s: got %0d bytes, expected %0d bytes of \"%s\"", name, got.size(), exp.size(), body);
        end else begin
            for (int i = 0; i < exp.size(); i++)
                if (got[i] !== exp[i] && bad < 0) bad = i;
            if (bad >= 0) begin
                n_fail++;
                $display("FAIL %s: byte %0d got %02h, expected %02h (\"%s\")", name, bad, got[bad], exp[bad], body);
            end
        end
        $display("line %s dut%0d: %0d bytes checked against \"%s\"", name, k, exp.size(), body);
    endtask

    initial begin
        int e;
        int t;

        vecs[0] = '{32'h2D00_1700, "H=045.0 T=023.0", "H=045 T=023"};
        vecs[1] = '{32'hFF0C_0005, "H=255.? T=000.5", "H=255 T=000"};
        vecs[2] = '{32'h0A00_0900, "H=010.0 T=009.0", "H=010 T=009"};
        vecs[3] = '{32'h6309_5A0A, "H=099.9 T=090.?", "H=099 T=090"};
        vecs[4] = '{32'h6400_0000, "H=100.0 T=000.0", "H=100 T=000"};

        clear_mon();
        for (int k = 0; k < 2; k++) begin
            stalled[k] = 1'b0;
            hold[k]    = 8'h00;
        end

        // Reset values
        reset = 1'b1;
        tick(3);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst_tx_data%0d", k), {24'd0, tx_data_v[k]}, 32'h0);
            check($sformatf("rst_tx_valid%0d", k), {31'd0, tx_valid_v[k]}, 32'h0);
            check($sformatf("rst_busy%0d", k), {31'd0, busy_v[k]}, 32'h0);
            check($sformatf("rst_frame_done%0d", k), {31'd0, frame_done_v[k]}, 32'h0);
            check($sformatf("rst_overrun%0d", k), {31'd0, overrun_v[k]}, 32'h0);
        end
        tick(1);
        reset = 1'b0;
        tick(2);

        // Latency, then a new edge landing exactly in the frame_done cycle
        clear_mon();
        tx_ready = 1'b1;
        start_frame(vecs[0].raw, e);
        @(negedge clk);
        check("busy_at_E", {31'd0, busy_v[1]}, 32'd0);
        tick(1);
        @(negedge clk);
        check("busy_at_E1", {31'd0, busy_v[1]}, 32'd1);
        t = 0;
        while (cyc < e + 25 && t < 100) begin
            tick(1);
            t++;
        end
        dht_done = 1'b0;
        tick(1);
        dht_done = 1'b1;
        wait_done(2, 200);
        check("first_valid1", first_v[1], e + 9);
        check("first_valid0", first_v[0], e + 9);
        check("frame_done_cyc1", fd_first[1], e + 26);
        check("frame_done_cyc0", fd_first[0], e + 22);
        check("back_to_back_done1", fd_last[1], e + 52);
        check("back_to_back_done0", fd_last[0], e + 48);
        check("no_overrun1", ov_cnt[1], 0);
        check("no_overrun0", ov_cnt[0], 0);
        check_line("timing", 1, vecs[0].line1, 2);
        check_line("timing", 0, vecs[0].line0, 2);

        // Table of readings with tx_ready held high
        for (int v = 0; v < 5; v++) begin
            clear_mon();
            tx_ready = 1'b1;
            start_frame(vecs[v].raw, e);
            wait_done(1, 100);
            tick(2);
            check_line($sformatf("vec%0d", v), 1, vecs[v].line1, 1);
            check_line($sformatf("vec%0d", v), 0, vecs[v].line0, 1);
            check($sformatf("vec%0d_done_count", v), fd_cnt[1], 1);
        end

        // Random stalls of three cycles
        clear_mon();
        stall_cnt = 0;
        tx_ready = 1'b0;
        start_frame(vecs[0].raw, e);
        t = 0;
        while (!(fd_cnt[0] >= 1 && fd_cnt[1] >= 1) && t < 1000) begin
            if ($urandom_range(0, 2) == 0) begin
                tx_ready = 1'b0;
                tick(3);
                t += 3;
            end else begin
                tx_ready = 1'b1;
                tick(1);
                t++;
            end
        end
        check("stall_frame_complete", {31'd0, (fd_cnt[0] >= 1 && fd_cnt[1] >= 1)}, 32'd1);
        tx_ready = 1'b1;
        tick(2);
        check_line("stall", 1, vecs[0].line1, 1);
        check_line("stall", 0, vecs[0].line0, 1);
        check("stall_seen", {31'd0, (stall_cnt > 0)}, 32'd1);

        // Second edge mid-frame with new data on the bus
        clear_mon();
        tx_ready = 1'b1;
        start_frame(vecs[1].raw, e);
        t = 0;
        while (q1.size() < 5 && t < 100) begin
            tick(1);
            t++;
        end
        dht_done = 1'b0;
        dht_raw  = 32'h1111_1111;
        tick(1);
        dht_done = 1'b1;
        wait_done(1, 100);
        tick(2);
        check("overrun_pulses1", ov_cnt[1], 1);
        check("overrun_pulses0", ov_cnt[0], 1);
        check_line("overrun", 1, vecs[1].line1, 1);
        check_line("overrun", 0, vecs[1].line0, 1);

        // Reset at byte 8 abandons the line; a later edge gives a full line
        clear_mon();
        start_frame(vecs[2].raw, e);
        t = 0;
        while (q1.size() < 8 && t < 100) begin
            tick(1);
            t++;
        end
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_valid1", {31'd0, tx_valid_v[1]}, 32'd0);
        check("rst_mid_valid0", {31'd0, tx_valid_v[0]}, 32'd0);
        check("rst_mid_busy1", {31'd0, busy_v[1]}, 32'd0);
        tick(30);
        check("rst_mid_no_done1", fd_cnt[1], 0);
        check("rst_mid_no_done0", fd_cnt[0], 0);
        clear_mon();
        start_frame(vecs[2].raw, e);
        wait_done(1, 100);
        tick(2);
        check_line("after_reset", 1, vecs[2].line1, 1);
        check_line("after_reset", 0, vecs[2].line0, 1);

        // dht_done already high when reset is released
        dht_done = 1'b1;
        reset = 1'b1;
        tick(2);
        clear_mon();
        reset = 1'b0;
        tick(40);
        check("held_high_no_valid1", valid_cnt[1], 0);
        check("held_high_no_valid0", valid_cnt[0], 0);
        check("held_high_busy1", {31'd0, busy_v[1]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
